// File: rtl/adc_pair_align.sv
// adc_pair_align: pairs trigger-started A/B ADC samples into one aligned strobe with timeout and fault flags
module adc_pair_align #(
  parameter int                 DATA_W         = 16,
  parameter int                 TIMEOUT_CYCLES = 4096,
  parameter logic [DATA_W-1:0]  OV_LIMIT       = 16'h8000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              trigger_i,
  input  logic              a_valid_i,
  input  logic [DATA_W-1:0] a_data_i,
  input  logic              b_valid_i,
  input  logic [DATA_W-1:0] b_data_i,
  input  logic              clear_i,
  output logic              pair_valid_o,
  output logic [DATA_W-1:0] a_data_o,
  output logic [DATA_W-1:0] b_data_o,
  output logic              timeout_o,
  output logic [7:0]        err_cnt_o,
  output logic              overrun_o,
  output logic              ov_fault_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, ARMED, EMIT} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] timer;
  logic [DATA_W-1:0] a_hold, b_hold;
  logic got_a, got_b, armed, emit, arm, complete, expire, tmo, ov;
  logic [7:0] err_base;
  always_comb begin
    armed    = state_q == ARMED;
    emit     = state_q == EMIT;
    arm      = trigger_i && !armed;
    complete = armed && (got_a || a_valid_i) && (got_b || b_valid_i);
    expire   = timer == LAST;
    tmo      = armed && expire && !complete;
    ov       = emit && (a_hold > OV_LIMIT || b_hold > OV_LIMIT);
    err_base = clear_i ? 8'd0 : err_cnt_o;
    state_d  = armed ? (complete ? EMIT : expire ? IDLE : ARMED) : (trigger_i ? ARMED : IDLE);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      timer        <= '0;
      got_a        <= 1'b0;
      got_b        <= 1'b0;
      a_hold       <= '0;
      b_hold       <= '0;
      pair_valid_o <= 1'b0;
      a_data_o     <= '0;
      b_data_o     <= '0;
      timeout_o    <= 1'b0;
      err_cnt_o    <= 8'd0;
      overrun_o    <= 1'b0;
      ov_fault_o   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer        <= arm ? '0 : (armed && !complete) ? timer + 1'b1 : timer;
      got_a        <= arm ? 1'b0 : (armed && a_valid_i) ? 1'b1 : got_a;
      got_b        <= arm ? 1'b0 : (armed && b_valid_i) ? 1'b1 : got_b;
      a_hold       <= (armed && a_valid_i) ? a_data_i : a_hold;
      b_hold       <= (armed && b_valid_i) ? b_data_i : b_hold;
      pair_valid_o <= complete;
      a_data_o     <= complete ? (a_valid_i ? a_data_i : a_hold) : a_data_o;
      b_data_o     <= complete ? (b_valid_i ? b_data_i : b_hold) : b_data_o;
      timeout_o    <= tmo;
      err_cnt_o    <= err_base + 8'(tmo && err_base != 8'hff);
      overrun_o    <= (armed && trigger_i) || (overrun_o && !clear_i);
      ov_fault_o   <= ov || (ov_fault_o && !clear_i);
    end
  end
endmodule

// File: tb/tb_adc_pair_align.sv
// tb_adc_pair_align: directed checks of pairing, timeout, overrun, over-limit and reset behaviour
module tb_adc_pair_align;
  logic clk_i = 0, rst_ni = 0, trigger_i = 0, a_valid_i = 0, b_valid_i = 0, clear_i = 0;
  logic [15:0] a_data_i = 0, b_data_i = 0, a_data_o, b_data_o;
  logic pair_valid_o, timeout_o, overrun_o, ov_fault_o;
  logic [7:0] err_cnt_o;
  int total = 0, bad = 0;
  adc_pair_align #(.DATA_W(16), .TIMEOUT_CYCLES(16), .OV_LIMIT(16'h8000)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .trigger_i(trigger_i),
    .a_valid_i(a_valid_i), .a_data_i(a_data_i), .b_valid_i(b_valid_i), .b_data_i(b_data_i),
    .clear_i(clear_i), .pair_valid_o(pair_valid_o), .a_data_o(a_data_o), .b_data_o(b_data_o),
    .timeout_o(timeout_o), .err_cnt_o(err_cnt_o), .overrun_o(overrun_o), .ov_fault_o(ov_fault_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic idle();
    trigger_i = 0; a_valid_i = 0; b_valid_i = 0; clear_i = 0;
  endtask
  task automatic test_reset();
    rst_ni = 0;
    #1;
    total++; if ({pair_valid_o, timeout_o, overrun_o, ov_fault_o} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", {pair_valid_o, timeout_o, overrun_o, ov_fault_o}); end
    total++; if ({a_data_o, b_data_o, err_cnt_o} !== 40'h0) begin bad++; $display("FAIL reset_data got=%h want=0", {a_data_o, b_data_o, err_cnt_o}); end
    @(negedge clk_i); @(negedge clk_i);
    rst_ni = 1;
  endtask
  task automatic test_basic();
    int pv = 0;
    for (int c = 0; c <= 9; c++) begin
      trigger_i = c == 0; a_valid_i = c == 5; a_data_i = 16'h1234; b_valid_i = c == 9; b_data_i = 16'h0ABC;
      @(negedge clk_i);
      if (c < 9) pv += int'(pair_valid_o);
    end
    idle();
    total++; if (pv != 0) begin bad++; $display("FAIL basic_early got=%0d want=0", pv); end
    total++; if (pair_valid_o !== 1'b1) begin bad++; $display("FAIL basic_strobe got=%b want=1", pair_valid_o); end
    total++; if (a_data_o !== 16'h1234 || b_data_o !== 16'h0ABC) begin bad++; $display("FAIL basic_data got=%h/%h want=1234/0abc", a_data_o, b_data_o); end
    total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL basic_tmo got=%b want=0", timeout_o); end
    @(negedge clk_i);
    total++; if (pair_valid_o !== 1'b0) begin bad++; $display("FAIL basic_one_cycle got=%b want=0", pair_valid_o); end
  endtask
  task automatic test_same_cycle();
    for (int c = 0; c <= 3; c++) begin
      trigger_i = c == 0; a_valid_i = c == 3; a_data_i = 16'h0100; b_valid_i = c == 3; b_data_i = 16'h0200;
      @(negedge clk_i);
    end
    idle();
    total++; if (pair_valid_o !== 1'b1 || a_data_o !== 16'h0100 || b_data_o !== 16'h0200) begin bad++; $display("FAIL same_pair got=%b %h/%h want=1 0100/0200", pair_valid_o, a_data_o, b_data_o); end
    @(negedge clk_i);
    total++; if (pair_valid_o !== 1'b0) begin bad++; $display("FAIL same_single got=%b want=0", pair_valid_o); end
  endtask
  task automatic test_timeout();
    int tc = 0;
    for (int c = 0; c <= 16; c++) begin
      trigger_i = c == 0; a_valid_i = c == 2; a_data_i = 16'h5555;
      @(negedge clk_i);
      if (c < 16) tc += int'(timeout_o);
    end
    idle();
    total++; if (tc != 0) begin bad++; $display("FAIL tmo_early got=%0d want=0", tc); end
    total++; if (timeout_o !== 1'b1 || pair_valid_o !== 1'b0) begin bad++; $display("FAIL tmo_strobe got=%b/%b want=1/0", timeout_o, pair_valid_o); end
    total++; if (err_cnt_o !== 8'd1) begin bad++; $display("FAIL tmo_cnt got=%0d want=1", err_cnt_o); end
    total++; if (a_data_o !== 16'h0100 || b_data_o !== 16'h0200) begin bad++; $display("FAIL tmo_hold got=%h/%h want=0100/0200", a_data_o, b_data_o); end
    @(negedge clk_i);
    total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL tmo_one_cycle got=%b want=0", timeout_o); end
  endtask
  task automatic test_expiry_race();
    for (int c = 0; c <= 16; c++) begin
      trigger_i = c == 0; a_valid_i = c == 1; a_data_i = 16'h0111; b_valid_i = c == 16; b_data_i = 16'h0222;
      @(negedge clk_i);
    end
    idle();
    total++; if (pair_valid_o !== 1'b1 || timeout_o !== 1'b0) begin bad++; $display("FAIL race_strobe got=%b/%b want=1/0", pair_valid_o, timeout_o); end
    total++; if (a_data_o !== 16'h0111 || b_data_o !== 16'h0222) begin bad++; $display("FAIL race_data got=%h/%h want=0111/0222", a_data_o, b_data_o); end
    @(negedge clk_i);
    total++; if (timeout_o !== 1'b0 || err_cnt_o !== 8'd1) begin bad++; $display("FAIL race_cnt got=%b/%0d want=0/1", timeout_o, err_cnt_o); end
  endtask
  task automatic test_overrun();
    int pv = 0;
    for (int c = 0; c <= 6; c++) begin
      trigger_i = c == 0 || c == 3; a_valid_i = c == 4; a_data_i = 16'h0333; b_valid_i = c == 6; b_data_i = 16'h0444;
      @(negedge clk_i);
      if (c < 6) pv += int'(pair_valid_o);
    end
    idle();
    total++; if (pv != 0 || pair_valid_o !== 1'b1) begin bad++; $display("FAIL ovr_timing got=%0d/%b want=0/1", pv, pair_valid_o); end
    total++; if (overrun_o !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b want=1", overrun_o); end
    clear_i = 1;
    @(negedge clk_i);
    idle();
    total++; if (overrun_o !== 1'b0 || err_cnt_o !== 8'd0) begin bad++; $display("FAIL ovr_clear got=%b/%0d want=0/0", overrun_o, err_cnt_o); end
    for (int c = 0; c <= 3; c++) begin
      trigger_i = c == 0 || c == 2; clear_i = c == 2; a_valid_i = c == 3; b_valid_i = c == 3;
      @(negedge clk_i);
    end
    idle();
    total++; if (overrun_o !== 1'b1 || pair_valid_o !== 1'b1) begin bad++; $display("FAIL ovr_set_wins got=%b/%b want=1/1", overrun_o, pair_valid_o); end
  endtask
  task automatic test_saturate();
    for (int k = 1; k <= 257; k++) begin
      for (int c = 0; c <= 16; c++) begin
        trigger_i = c == 0; clear_i = k == 257 && c == 16;
        @(negedge clk_i);
      end
      idle();
      if (k == 254) begin total++; if (err_cnt_o !== 8'd254) begin bad++; $display("FAIL sat_254 got=%0d want=254", err_cnt_o); end end
      if (k == 256) begin total++; if (err_cnt_o !== 8'd255) begin bad++; $display("FAIL sat_256 got=%0d want=255", err_cnt_o); end end
      if (k == 257) begin total++; if (err_cnt_o !== 8'd1) begin bad++; $display("FAIL sat_clear_wins got=%0d want=1", err_cnt_o); end end
      @(negedge clk_i);
    end
  endtask
  task automatic test_ov_reset();
    for (int c = 0; c <= 2; c++) begin
      trigger_i = c == 0; a_valid_i = c == 2; a_data_i = 16'h8000; b_valid_i = c == 2; b_data_i = 16'h8000;
      @(negedge clk_i);
    end
    idle();
    @(negedge clk_i);
    total++; if (ov_fault_o !== 1'b0) begin bad++; $display("FAIL ov_boundary got=%b want=0", ov_fault_o); end
    for (int c = 0; c <= 2; c++) begin
      trigger_i = c == 0; a_valid_i = c == 2; a_data_i = 16'h8001; b_valid_i = c == 2; b_data_i = 16'h0001;
      @(negedge clk_i);
    end
    idle();
    total++; if (pair_valid_o !== 1'b1 || a_data_o !== 16'h8001) begin bad++; $display("FAIL ov_pair got=%b/%h want=1/8001", pair_valid_o, a_data_o); end
    @(negedge clk_i); @(negedge clk_i);
    total++; if (ov_fault_o !== 1'b1) begin bad++; $display("FAIL ov_sticky got=%b want=1", ov_fault_o); end
    trigger_i = 1; @(negedge clk_i);
    idle(); a_valid_i = 1; a_data_i = 16'h0777; @(negedge clk_i);
    idle();
    rst_ni = 0;
    #1;
    total++; if ({pair_valid_o, timeout_o, overrun_o, ov_fault_o, a_data_o, b_data_o, err_cnt_o} !== 44'h0) begin bad++; $display("FAIL mid_reset got=%h want=0", {pair_valid_o, timeout_o, overrun_o, ov_fault_o, a_data_o, b_data_o, err_cnt_o}); end
    @(negedge clk_i);
    rst_ni = 1;
    b_valid_i = 1; b_data_i = 16'h0888;
    @(negedge clk_i);
    idle();
    @(negedge clk_i);
    total++; if (pair_valid_o !== 1'b0 || b_data_o !== 16'h0) begin bad++; $display("FAIL mid_abandon got=%b/%h want=0/0", pair_valid_o, b_data_o); end
    for (int c = 0; c <= 1; c++) begin
      trigger_i = c == 0; a_valid_i = c == 1; a_data_i = 16'h0999; b_valid_i = c == 1; b_data_i = 16'h0AAA;
      @(negedge clk_i);
    end
    idle();
    total++; if (pair_valid_o !== 1'b1 || b_data_o !== 16'h0AAA) begin bad++; $display("FAIL post_reset got=%b/%h want=1/0aaa", pair_valid_o, b_data_o); end
  endtask
  initial begin
    @(negedge clk_i);
    test_reset();
    test_basic();
    test_same_cycle();
    test_timeout();
    test_expiry_race();
    test_overrun();
    test_saturate();
    test_ov_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adc_pair_align.md
ADC_PAIR_ALIGN -- requirements
Module: adc_pair_align

Interface
REQ-001 Parameter DATA_W, default 16, sample width of both channels.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096, clk_i cycles allowed from trigger to pair completion.
REQ-003 Parameter OV_LIMIT, default 16'h8000, over-limit threshold applied to both samples.
REQ-004 clk_i  input  1  system clock; rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 trigger_i  input  1  single-cycle conversion-start pulse from the PWM modulator.
REQ-006 a_valid_i  input  1  channel A (flying-cap ADC) data-ready pulse; a_data_i  input  DATA_W  channel A sample.
REQ-007 b_valid_i  input  1  channel B (Vout ADC) data-ready pulse; b_data_i  input  DATA_W  channel B sample.
REQ-008 clear_i  input  1  synchronous clear of sticky flags and error counter.
REQ-009 pair_valid_o  output  1  one-cycle strobe: aligned pair available, drives controller clock-enable.
REQ-010 a_data_o, b_data_o  output  DATA_W each  aligned sample pair, held between strobes.
REQ-011 timeout_o  output  1  one-cycle strobe on pair timeout.
REQ-012 err_cnt_o  output  8  saturating timeout count.
REQ-013 overrun_o  output  1  sticky: trigger_i arrived while a pair was pending.
REQ-014 ov_fault_o  output  1  sticky: emitted sample exceeded OV_LIMIT.

Function
REQ-015 FSM states IDLE, ARMED, EMIT; reset state IDLE.
REQ-016 IDLE: a_valid_i/b_valid_i ignored; trigger_i -> ARMED, got_a/got_b flags cleared, timer cleared to 0.
REQ-017 ARMED: a_valid_i latches a_data_i into holding reg, sets got_a; b_valid_i likewise for B; repeat valid on same channel overwrites holding reg.
REQ-018 ARMED: timer increments by 1 each cycle the pair is incomplete.
REQ-019 ARMED -> EMIT in the cycle both flags become set (including both valids in the same cycle, or second valid with first already held).
REQ-020 EMIT lasts exactly one cycle: pair_valid_o=1, a_data_o/b_data_o updated from holding regs in that same cycle; latency = 1 cycle after the completing valid.
REQ-021 EMIT -> IDLE, or -> ARMED (flags/timer cleared) if trigger_i=1 during EMIT.
REQ-022 ARMED with timer == TIMEOUT_CYCLES-1 and pair not completed this cycle -> IDLE; timeout_o=1 next cycle for one cycle; err_cnt_o += 1, saturating at 255; a_data_o/b_data_o unchanged.
REQ-023 Completing valid in the same cycle as timer expiry: pair wins, EMIT entered, no timeout.
REQ-024 trigger_i while ARMED: ignored for sequencing (timer not restarted), overrun_o set.
REQ-025 ov_fault_o set in EMIT cycle if a holding value > OV_LIMIT or b holding value > OV_LIMIT (unsigned compare); pair still emitted.
REQ-026 clear_i=1 clears overrun_o, ov_fault_o, err_cnt_o; set event in same cycle wins over clear (flag=1, counter=1).
REQ-027 pair_valid_o and timeout_o never asserted in the same cycle.
REQ-028 All outputs registered; no combinational input-to-output path.

Reset
REQ-029 rst_ni low: FSM IDLE, timer 0, got flags 0, holding regs 0, pair_valid_o 0, a_data_o 0, b_data_o 0, timeout_o 0, err_cnt_o 0, overrun_o 0, ov_fault_o 0.
REQ-030 Reset asserted mid-pair abandons the pair with no strobe; first pair after release requires a new trigger_i.

Verification
REQ-031 trigger; A=16'h1234 at +5; B=16'h0ABC at +9 -> pair_valid_o at +10, a_data_o=16'h1234, b_data_o=16'h0ABC, no timeout.
REQ-032 trigger; A and B valid same cycle +3 (16'h0100, 16'h0200) -> single pair_valid_o at +4 with those values.
REQ-033 trigger; only A valid; TIMEOUT_CYCLES=16 -> timeout_o one cycle, err_cnt_o=1, outputs keep prior pair; 256 timeouts -> err_cnt_o stays 255.
REQ-034 B valid on last timer cycle (expiry cycle) -> pair_valid_o, timeout_o stays 0, err_cnt_o unchanged.
REQ-035 second trigger while ARMED -> overrun_o=1, pair still emitted on original timing; clear_i -> overrun_o=0.
REQ-036 A sample 16'h8001 emitted -> ov_fault_o=1 sticky; rst_ni pulse mid-ARMED -> no strobe, all outputs 0.
